// File: rtl/mem_stage_ext.sv
// Memory pipeline stage (EX/MEM -> MEM/WB): RV32 byte/half/word loads and stores with optional wait states.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (flag misaligned H/W accesses instead of force-aligning them).
module mem_stage_ext #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regwrite_m,
    input  logic [1:0]      result_src_m,
    input  logic            memwrite_m,
    input  logic            memread_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] writedata_m,
    input  logic [4:0]      rd_m,
    input  logic [XLEN-1:0] pc_plus_4_m,
    output logic            mem_busy,
    output logic            misaligned_exc,
    output logic [XLEN-1:0] readdata,
    output logic            mem_wb_regwrite,
    output logic [1:0]      mem_wb_result_src,
    output logic [XLEN-1:0] mem_wb_alu_result,
    output logic [XLEN-1:0] mem_wb_pc_plus_4,
    output logic [4:0]      mem_wb_rd
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              exec_s;

    logic              hold_regwrite_q, hold_memwrite_q, hold_memread_q;
    logic [1:0]        hold_result_src_q;
    logic [2:0]        hold_funct3_q;
    logic [XLEN-1:0]   hold_alu_q, hold_wdata_q, hold_pc4_q;
    logic [4:0]        hold_rd_q;

    logic              op_regwrite_s, op_memwrite_s, op_memread_s, mem_op_s, load_s;
    logic [1:0]        op_result_src_s;
    logic [2:0]        op_funct3_s;
    logic [XLEN-1:0]   op_addr_s, op_wdata_s, op_pc4_s;
    logic [4:0]        op_rd_s;

    logic              rsvd_s, misalign_s, bad_s, we_s;
    logic [1:0]        lo_s;
    logic [AW-1:0]     idx_s;
    logic [3:0]        be_s;
    logic [31:0]       wword_s, rword_s, shifted_s, ext_s;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              mem_wb_regwrite_q, misaligned_exc_q;
    logic [1:0]        mem_wb_result_src_q;
    logic [XLEN-1:0]   readdata_q, mem_wb_alu_result_q, mem_wb_pc_plus_4_q;
    logic [4:0]        mem_wb_rd_q;

    logic              unused_s;

    // While waiting, the access is driven from the captured copy of the instruction.
    assign op_regwrite_s   = (state_q == S_WAIT) ? hold_regwrite_q   : regwrite_m;
    assign op_result_src_s = (state_q == S_WAIT) ? hold_result_src_q : result_src_m;
    assign op_memwrite_s   = (state_q == S_WAIT) ? hold_memwrite_q   : memwrite_m;
    assign op_memread_s    = (state_q == S_WAIT) ? hold_memread_q    : memread_m;
    assign op_funct3_s     = (state_q == S_WAIT) ? hold_funct3_q     : funct3_m;
    assign op_addr_s       = (state_q == S_WAIT) ? hold_alu_q        : alu_result_m;
    assign op_wdata_s      = (state_q == S_WAIT) ? hold_wdata_q      : writedata_m;
    assign op_pc4_s        = (state_q == S_WAIT) ? hold_pc4_q        : pc_plus_4_m;
    assign op_rd_s         = (state_q == S_WAIT) ? hold_rd_q         : rd_m;

    assign mem_op_s = op_memread_s | op_memwrite_s;
    assign load_s   = op_memread_s & ~op_memwrite_s;
    assign idx_s    = op_addr_s[AW+1:2];
    assign mem_busy = (state_q == S_WAIT);
    assign unused_s = ^op_addr_s[XLEN-1:AW+2];

    // FSM next state, wait counter and the execute strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op_s && (WAIT_CYCLES != 0)) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    exec_s = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    exec_s  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Access decode: reserved funct3, alignment, byte enables, store merge data and load extension.
    always_comb begin
        case (op_funct3_s)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: rsvd_s = 1'b0;
            default:                                rsvd_s = 1'b1;
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        lo_s       = op_addr_s[1:0];
        misalign_s = ((op_funct3_s[1:0] == 2'b01) && op_addr_s[0]) ||
                     ((op_funct3_s[1:0] == 2'b10) && (op_addr_s[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
        case (op_funct3_s[1:0])
            2'b00:   lo_s = op_addr_s[1:0];
            2'b01:   lo_s = {op_addr_s[1], 1'b0};
            default: lo_s = 2'b00;
        endcase
`endif
        bad_s = rsvd_s | misalign_s;
        we_s  = exec_s & op_memwrite_s & ~bad_s;
        case (op_funct3_s[1:0])
            2'b00: begin
                be_s    = 4'b0001 << lo_s;
                wword_s = {4{op_wdata_s[7:0]}};
            end
            2'b01: begin
                be_s    = lo_s[1] ? 4'b1100 : 4'b0011;
                wword_s = {2{op_wdata_s[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wword_s = op_wdata_s;
            end
        endcase
        rword_s   = mem_q[idx_s];
        shifted_s = rword_s >> {lo_s, 3'b000};
        case (op_funct3_s)
            3'b000:  ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b100:  ext_s = {24'h000000, shifted_s[7:0]};
            3'b101:  ext_s = {16'h0000, shifted_s[15:0]};
            default: ext_s = shifted_s;
        endcase
    end

    // Data array with byte-lane writes; intentionally has no reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    // FSM, hold registers and MEM/WB output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= S_IDLE;
            cnt_q               <= 4'd0;
            hold_regwrite_q     <= 1'b0;
            hold_result_src_q   <= 2'b00;
            hold_memwrite_q     <= 1'b0;
            hold_memread_q      <= 1'b0;
            hold_funct3_q       <= 3'b000;
            hold_alu_q          <= '0;
            hold_wdata_q        <= '0;
            hold_pc4_q          <= '0;
            hold_rd_q           <= 5'd0;
            mem_wb_regwrite_q   <= 1'b0;
            mem_wb_result_src_q <= 2'b00;
            mem_wb_alu_result_q <= '0;
            mem_wb_pc_plus_4_q  <= '0;
            mem_wb_rd_q         <= 5'd0;
            misaligned_exc_q    <= 1'b0;
            readdata_q          <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE) begin
                hold_regwrite_q   <= regwrite_m;
                hold_result_src_q <= result_src_m;
                hold_memwrite_q   <= memwrite_m;
                hold_memread_q    <= memread_m;
                hold_funct3_q     <= funct3_m;
                hold_alu_q        <= alu_result_m;
                hold_wdata_q      <= writedata_m;
                hold_pc4_q        <= pc_plus_4_m;
                hold_rd_q         <= rd_m;
            end
            if (exec_s) begin
                mem_wb_regwrite_q   <= op_regwrite_s & ~(mem_op_s & bad_s);
                mem_wb_result_src_q <= op_result_src_s;
                mem_wb_alu_result_q <= op_addr_s;
                mem_wb_pc_plus_4_q  <= op_pc4_s;
                mem_wb_rd_q         <= op_rd_s;
                misaligned_exc_q    <= mem_op_s & misalign_s;
                if (mem_op_s && rsvd_s) begin
                    readdata_q <= '0;
                end else if (load_s && misalign_s) begin
                    readdata_q <= '0;
                end else if (load_s) begin
                    readdata_q <= ext_s;
                end else begin
                    readdata_q <= readdata_q;
                end
            end else begin
                mem_wb_regwrite_q <= 1'b0;
                misaligned_exc_q  <= 1'b0;
            end
        end
    end

    assign misaligned_exc    = misaligned_exc_q;
    assign readdata          = readdata_q;
    assign mem_wb_regwrite   = mem_wb_regwrite_q;
    assign mem_wb_result_src = mem_wb_result_src_q;
    assign mem_wb_alu_result = mem_wb_alu_result_q;
    assign mem_wb_pc_plus_4  = mem_wb_pc_plus_4_q;
    assign mem_wb_rd         = mem_wb_rd_q;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Directed bench for mem_stage_ext: one instance with no wait states, one with WAIT_CYCLES=3.
module tb_mem_stage_ext;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite_m, memwrite_m, memread_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, writedata_m, pc_plus_4_m;
    logic [4:0]  rd_m;

    logic        a_busy, a_exc, a_rw;
    logic [1:0]  a_rs;
    logic [31:0] a_rdata, a_alu, a_pc4;
    logic [4:0]  a_rd;
    logic        b_busy, b_exc, b_rw;
    logic [1:0]  b_rs;
    logic [31:0] b_rdata, b_alu, b_pc4;
    logic [4:0]  b_rd;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_stage_ext #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .regwrite_m(regwrite_m), .result_src_m(result_src_m),
        .memwrite_m(memwrite_m), .memread_m(memread_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .writedata_m(writedata_m), .rd_m(rd_m),
        .pc_plus_4_m(pc_plus_4_m), .mem_busy(a_busy), .misaligned_exc(a_exc),
        .readdata(a_rdata), .mem_wb_regwrite(a_rw), .mem_wb_result_src(a_rs),
        .mem_wb_alu_result(a_alu), .mem_wb_pc_plus_4(a_pc4), .mem_wb_rd(a_rd)
    );

    mem_stage_ext #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .regwrite_m(regwrite_m), .result_src_m(result_src_m),
        .memwrite_m(memwrite_m), .memread_m(memread_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .writedata_m(writedata_m), .rd_m(rd_m),
        .pc_plus_4_m(pc_plus_4_m), .mem_busy(b_busy), .misaligned_exc(b_exc),
        .readdata(b_rdata), .mem_wb_regwrite(b_rw), .mem_wb_result_src(b_rs),
        .mem_wb_alu_result(b_alu), .mem_wb_pc_plus_4(b_pc4), .mem_wb_rd(b_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic rw, input logic [1:0] rs, input logic mw, input logic mr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
        regwrite_m   = rw;
        result_src_m = rs;
        memwrite_m   = mw;
        memread_m    = mr;
        funct3_m     = f3;
        alu_result_m = a;
        writedata_m  = wd;
        rd_m         = rd;
        pc_plus_4_m  = a + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", a_rdata, 32'h0);
        chk("rst_regwrite", {31'd0, a_rw}, 32'h0);
        chk("rst_alu", a_alu, 32'h0);
        chk("rst_busy3", {31'd0, b_busy}, 32'h0);
        reset = 1'b0;

        // Word store then load, zero wait states
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0); step();
        chk("sw_busy", {31'd0, a_busy}, 32'h0);
        chk("sw_alu", a_alu, 32'h10);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 5'd5); step();
        chk("lw_data", a_rdata, 32'hDEADBEEF);
        chk("lw_regwrite", {31'd0, a_rw}, 32'h1);
        chk("lw_rd", {27'd0, a_rd}, 32'd5);
        chk("lw_busy", {31'd0, a_busy}, 32'h0);

        // Byte store, lane preservation, sign/zero extension
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h20, 32'hA1B2C3D4, 5'd0); step();
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b000, 32'h21, 32'h12345680, 5'd0); step();
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 32'h21, 32'h0, 5'd6); step();
        chk("lb", a_rdata, 32'hFFFFFF80);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b100, 32'h21, 32'h0, 5'd6); step();
        chk("lbu", a_rdata, 32'h00000080);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 5'd6); step();
        chk("sb_lanes", a_rdata, 32'hA1B280D4);

        // Halfword store in upper lane
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h30, 32'h11223344, 5'd0); step();
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b001, 32'h32, 32'hABCD8001, 5'd0); step();
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b001, 32'h32, 32'h0, 5'd7); step();
        chk("lh", a_rdata, 32'hFFFF8001);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b101, 32'h32, 32'h0, 5'd7); step();
        chk("lhu", a_rdata, 32'h00008001);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 5'd7); step();
        chk("sh_lanes", a_rdata, 32'h80013344);

        // Halfword load at odd address: trap or force-align
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b001, 32'h33, 32'h0, 5'd7); step();
        chk("lh_odd_data", a_rdata, TRAP ? 32'h0 : 32'hFFFF8001);
        chk("lh_odd_exc", {31'd0, a_exc}, TRAP ? 32'h1 : 32'h0);

        // Address wrap modulo array size
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h400, 32'h12345678, 5'd0); step();
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h000, 32'h0, 5'd8); step();
        chk("wrap", a_rdata, 32'h12345678);

        // Misaligned word store
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h40, 32'h55555555, 5'd0); step();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h41, 32'hCAFEF00D, 5'd8); step();
        chk("mis_exc", {31'd0, a_exc}, TRAP ? 32'h1 : 32'h0);
        chk("mis_regwrite", {31'd0, a_rw}, TRAP ? 32'h0 : 32'h1);
        chk("mis_rdata_kept", a_rdata, 32'h12345678);

        // Non-memory op passes fields, leaves readdata
        drive(1'b1, 2'b10, 1'b0, 1'b0, 3'b010, 32'h7777, 32'h0, 5'd9); step();
        chk("alu_exc_clear", {31'd0, a_exc}, 32'h0);
        chk("alu_rdata_kept", a_rdata, 32'h12345678);
        chk("alu_regwrite", {31'd0, a_rw}, 32'h1);
        chk("alu_result", a_alu, 32'h7777);
        chk("alu_pc4", a_pc4, 32'h777B);
        chk("alu_src", {30'd0, a_rs}, 32'h2);
        chk("alu_rd", {27'd0, a_rd}, 32'd9);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 5'd9); step();
        chk("mis_mem", a_rdata, TRAP ? 32'h55555555 : 32'hCAFEF00D);

        // Reserved funct3, then load/store both set
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 5'd10); step();
        chk("rsvd_rdata", a_rdata, 32'h0);
        chk("rsvd_regwrite", {31'd0, a_rw}, 32'h0);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 5'd10); step();
        chk("lw_again", a_rdata, 32'hDEADBEEF);
        drive(1'b0, 2'b01, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0BADF00D, 5'd10); step();
        chk("both_rdata_kept", a_rdata, 32'hDEADBEEF);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 5'd10); step();
        chk("both_stored", a_rdata, 32'h0BADF00D);

        // Wait-state instance
        reset = 1'b1;
        #2;
        reset = 1'b0;
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h50, 32'h600DCAFE, 5'd0);
        repeat (4) step();
        chk("w_sw_done_busy", {31'd0, b_busy}, 32'h0);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h50, 32'h0, 5'd7);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("w_busy_%0d", i), {31'd0, b_busy}, 32'h1);
            chk($sformatf("w_bubble_%0d", i), {31'd0, b_rw}, 32'h0);
        end
        step();
        chk("w_done_busy", {31'd0, b_busy}, 32'h0);
        chk("w_done_rw", {31'd0, b_rw}, 32'h1);
        chk("w_done_data", b_rdata, 32'h600DCAFE);
        chk("w_done_rd", {27'd0, b_rd}, 32'd7);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 32'h99, 32'h0, 5'd3); step();
        chk("w_alu_busy", {31'd0, b_busy}, 32'h0);
        chk("w_alu_rw", {31'd0, b_rw}, 32'h1);
        chk("w_alu_result", b_alu, 32'h99);

        // Reset while a store is waiting aborts it
        drive(1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h50, 32'hBAD0BAD0, 5'd0); step();
        chk("abort_busy_before", {31'd0, b_busy}, 32'h1);
        reset = 1'b1;
        #2;
        chk("abort_busy", {31'd0, b_busy}, 32'h0);
        chk("abort_alu", b_alu, 32'h0);
        chk("abort_rdata", b_rdata, 32'h0);
        reset = 1'b0;
        drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 32'h50, 32'h0, 5'd4);
        repeat (4) step();
        chk("abort_old_value", b_rdata, 32'h600DCAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
